// File: rtl/tsip_tx_scheduler.sv
// tsip_tx_scheduler: round-robin sharing of the TSIP UART transmitter between
// the power-up sequencer (port 0) and the host command path (port 1).
// It latches the granted packet and sends it as DLE, ID, payload, DLE, ETX.
// Any ID or payload byte equal to DLE is sent twice.
// Each byte is handed to uart_tx with a DV strobe, and the scheduler waits
// for the matching done pulse before moving on.
// Optional feature: define TSIP_INTERPACKET_GAP_EN to hold GAP_CLKS idle
// clocks after every packet. Without it, the scheduler returns to IDLE
// immediately after ETX.
//
//  state | meaning
//  IDLE  | no packet owned, arbitrating requests
//  ISSUE | strobe current phase byte into uart_tx
//  WAIT  | byte in flight, waiting for i_tx_done
//  GAP   | inter-packet quiet time (macro builds only)
module tsip_tx_scheduler #(
   parameter int MAX_LEN  = 8,
   parameter int GAP_CLKS = 10420
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req0,
   input  logic                 i_req1,
   input  logic [7:0]           i_id0,
   input  logic [7:0]           i_id1,
   input  logic [3:0]           i_len0,
   input  logic [3:0]           i_len1,
   input  logic [8*MAX_LEN-1:0] i_payload0,
   input  logic [8*MAX_LEN-1:0] i_payload1,
   output logic                 o_gnt0,
   output logic                 o_gnt1,
   output logic                 o_done0,
   output logic                 o_done1,
   output logic                 o_busy,
   output logic                 o_tx_dv,
   output logic [7:0]           o_tx_byte,
   input  logic                 i_tx_done
);

   localparam logic [7:0] DLE       = 8'h10;
   localparam logic [7:0] ETX       = 8'h03;
   localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

`ifdef TSIP_INTERPACKET_GAP_EN
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;
   localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
   logic [GW-1:0] gap_cnt_q;
`else
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
`endif

   typedef enum logic [2:0] {
      P_HDR_DLE, P_ID, P_PAYLOAD, P_STUFF, P_TRL_DLE, P_ETX
   } phase_t;

   state_t               state_q;
   phase_t               phase_q;
   logic                 rr_q;
   logic                 owner_q;
   logic [7:0]           id_q;
   logic [3:0]           len_q;
   logic [3:0]           idx_q;
   logic [8*MAX_LEN-1:0] payload_q;
   logic                 gnt0_q, gnt1_q, done0_q, done1_q, busy_q, tx_dv_q;
   logic [7:0]           tx_byte_q;

   logic                 any_req;
   logic                 gnt_port;
   logic [3:0]           len_raw;
   logic [3:0]           len_clamp;
   logic [3:0]           idx_inc;
   logic [8*MAX_LEN-1:0] pay_shift;
   logic [7:0]           cur_byte;
   phase_t               phase_after_id_d;
   phase_t               phase_after_pay_d;

   assign any_req   = i_req0 | i_req1;
   // Contention goes to the rr port; otherwise the lone requester wins.
   assign gnt_port  = (i_req0 & i_req1) ? rr_q : i_req1;
   assign len_raw   = gnt_port ? i_len1 : i_len0;
   assign len_clamp = (len_raw > MAX_LEN_L) ? MAX_LEN_L : len_raw;
   assign idx_inc   = idx_q + 4'd1;
   assign pay_shift = payload_q >> {idx_q, 3'b000};

   // idx_q always names the next payload byte still to be sent, so the same
   // test serves the ID and STUFF exits.
   assign phase_after_id_d  = (idx_q < len_q)   ? P_PAYLOAD : P_TRL_DLE;
   assign phase_after_pay_d = (idx_inc < len_q) ? P_PAYLOAD : P_TRL_DLE;

   // Byte selected by the current framing phase.
   always_comb begin
      cur_byte = 8'h00;
      case (phase_q)
         P_HDR_DLE: cur_byte = DLE;
         P_ID:      cur_byte = id_q;
         P_PAYLOAD: cur_byte = pay_shift[7:0];
         P_STUFF:   cur_byte = DLE;
         P_TRL_DLE: cur_byte = DLE;
         P_ETX:     cur_byte = ETX;
         default:   cur_byte = 8'h00;
      endcase
   end

   // Arbitration, framing sequencer and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         phase_q   <= P_HDR_DLE;
         rr_q      <= 1'b0;
         owner_q   <= 1'b0;
         id_q      <= 8'h00;
         len_q     <= 4'd0;
         idx_q     <= 4'd0;
         payload_q <= '0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         busy_q    <= 1'b0;
         tx_dv_q   <= 1'b0;
         tx_byte_q <= 8'h00;
`ifdef TSIP_INTERPACKET_GAP_EN
         gap_cnt_q <= '0;
`endif
      end else begin
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         tx_dv_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  owner_q   <= gnt_port;
                  rr_q      <= ~gnt_port;
                  id_q      <= gnt_port ? i_id1 : i_id0;
                  payload_q <= gnt_port ? i_payload1 : i_payload0;
                  len_q     <= len_clamp;
                  idx_q     <= 4'd0;
                  phase_q   <= P_HDR_DLE;
                  gnt0_q    <= ~gnt_port;
                  gnt1_q    <= gnt_port;
                  busy_q    <= 1'b1;
                  state_q   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               tx_byte_q <= cur_byte;
               tx_dv_q   <= 1'b1;
               state_q   <= S_WAIT;
            end
            S_WAIT: begin
               if (i_tx_done) begin
                  state_q <= S_ISSUE;
                  case (phase_q)
                     P_HDR_DLE: phase_q <= P_ID;
                     P_ID:      phase_q <= (tx_byte_q == DLE) ? P_STUFF : phase_after_id_d;
                     P_PAYLOAD: begin
                        idx_q   <= idx_inc;
                        phase_q <= (tx_byte_q == DLE) ? P_STUFF : phase_after_pay_d;
                     end
                     P_STUFF:   phase_q <= phase_after_id_d;
                     P_TRL_DLE: phase_q <= P_ETX;
                     default: begin
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
`ifdef TSIP_INTERPACKET_GAP_EN
                        gap_cnt_q <= GW'(GAP_CLKS - 1);
                        state_q   <= S_GAP;
`else
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
`endif
                     end
                  endcase
               end
            end
`ifdef TSIP_INTERPACKET_GAP_EN
            S_GAP: begin
               if (gap_cnt_q == '0) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_gnt0    = gnt0_q;
   assign o_gnt1    = gnt1_q;
   assign o_done0   = done0_q;
   assign o_done1   = done1_q;
   assign o_busy    = busy_q;
   assign o_tx_dv   = tx_dv_q;
   assign o_tx_byte = tx_byte_q;

endmodule
